// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state codes, opcodes and datapath select encodings for the multicycle controller.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_outdec.sv
// rtl/multicycle_control_outdec.sv - Moore output decode from state; only FETCH looks at MemReady.
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   MemReady,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only update on the cycle the instruction word actually arrives
        ctrl.ir_write  = MemReady;
        ctrl.pc_write  = MemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM with retire counter.
// Define ADDI_SUPPORT_EN to enable the addi (opcode 0x08) path; otherwise it decodes as illegal.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        Illegal,
  output logic [3:0]  State,
  output logic [31:0] RetireCount
);

  state_t      state;
  state_t      state_next;
  logic        is_store;
  logic        illegal_raw;
  logic        retire_en;
  logic [31:0] retire_cnt;
  ctrl_t       ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      is_store   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      // Opcode is only valid in DECODE, so MEMADR steers on the latched load/store choice
      if (state == S_DECODE)
        is_store <= (Opcode == OP_SW);
      if (retire_en)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    state_next  = state;
    illegal_raw = 1'b0;
    case (state)
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JUMP;
`ifdef ADDI_SUPPORT_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_next = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
`ifdef ADDI_SUPPORT_EN
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  // An instruction retires when any execution state hands back to FETCH; DECODE->FETCH is an illegal abort
  assign retire_en = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);

  multicycle_control_outdec u_outdec (
    .state    (state),
    .MemReady (MemReady),
    .ctrl     (ctrl)
  );

  assign PCWrite     = ~reset & ctrl.pc_write;
  assign PCWriteCond = ~reset & ctrl.pc_write_cond;
  assign IorD        = ~reset & ctrl.iord;
  assign MemRead     = ~reset & ctrl.mem_read;
  assign MemWrite    = ~reset & ctrl.mem_write;
  assign IRWrite     = ~reset & ctrl.ir_write;
  assign MemtoReg    = ~reset & ctrl.mem_to_reg;
  assign RegDst      = ~reset & ctrl.reg_dst;
  assign RegWrite    = ~reset & ctrl.reg_write;
  assign ALUSrcA     = ~reset & ctrl.alu_src_a;
  assign ALUSrcB     = {2{~reset}} & ctrl.alu_src_b;
  assign ALUOp       = {2{~reset}} & ctrl.alu_op;
  assign PCSource    = {2{~reset}} & ctrl.pc_source;
  assign Illegal     = ~reset & illegal_raw;
  assign State       = state;
  assign RetireCount = retire_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control; honours ADDI_SUPPORT_EN.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic [31:0] RetireCount;
  logic [16:0] cw;

  int n_assert = 0;
  int n_fail   = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal}
  localparam logic [16:0] CW_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CW_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] CW_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] CW_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] CW_ILLEGAL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] CW_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] CW_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CW_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] CW_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CW_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] CW_ALUWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] CW_BEQ     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] CW_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] CW_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .Illegal     (Illegal),
    .State       (State),
    .RetireCount (RetireCount)
  );

  always #5 clk = ~clk;

  assign cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [16:0] cwe);
    chk({tag, "_state"}, {28'd0, State}, {28'd0, st});
    chk({tag, "_ctrl"}, {15'd0, cw}, {15'd0, cwe});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    Opcode   = 6'h23;
    MemReady = 1'b1;
    #2;
    expect_cyc("reset", 4'd0, CW_ZERO);
    chk("reset_retire", RetireCount, 32'd0);
    step;
    expect_cyc("reset_held", 4'd0, CW_ZERO);
    reset = 1'b0;
    #1;
    expect_cyc("first_fetch", 4'd0, CW_FETCH);

    // lw: 0,1,2,3,4,0 ; opcode disturbed after DECODE must not matter
    step; expect_cyc("lw_decode", 4'd1, CW_DECODE);
    step; Opcode = 6'h2B; #1; expect_cyc("lw_memadr", 4'd2, CW_MEMADR);
    step; expect_cyc("lw_memrd", 4'd3, CW_MEMRD);
    step; expect_cyc("lw_memwb", 4'd4, CW_MEMWB);
    step; expect_cyc("lw_fetch", 4'd0, CW_FETCH);
    chk("lw_retire", RetireCount, 32'd1);

    // sw with three MemReady=0 cycles in MEMWR
    Opcode = 6'h2B;
    step; expect_cyc("sw_decode", 4'd1, CW_DECODE);
    step; expect_cyc("sw_memadr", 4'd2, CW_MEMADR);
    step; MemReady = 1'b0; #1; expect_cyc("sw_memwr1", 4'd5, CW_MEMWR);
    step; expect_cyc("sw_memwr2", 4'd5, CW_MEMWR);
    step; expect_cyc("sw_memwr3", 4'd5, CW_MEMWR);
    chk("sw_retire_stall", RetireCount, 32'd1);
    step; MemReady = 1'b1; #1; expect_cyc("sw_memwr4", 4'd5, CW_MEMWR);
    step; expect_cyc("sw_fetch", 4'd0, CW_FETCH);
    chk("sw_retire", RetireCount, 32'd2);

    // FETCH stall, then illegal opcode 0x3F
    MemReady = 1'b0; Opcode = 6'h3F; #1;
    expect_cyc("fetch_stall1", 4'd0, CW_FSTALL);
    step; expect_cyc("fetch_stall2", 4'd0, CW_FSTALL);
    MemReady = 1'b1; #1;
    expect_cyc("fetch_ready", 4'd0, CW_FETCH);
    step; expect_cyc("ill_decode", 4'd1, CW_ILLEGAL);
    step; expect_cyc("ill_fetch", 4'd0, CW_FETCH);
    chk("ill_retire", RetireCount, 32'd2);

    // beq then j
    Opcode = 6'h04;
    step; expect_cyc("beq_decode", 4'd1, CW_DECODE);
    step; expect_cyc("beq_exec", 4'd8, CW_BEQ);
    step; expect_cyc("beq_fetch", 4'd0, CW_FETCH);
    Opcode = 6'h02;
    step; expect_cyc("j_decode", 4'd1, CW_DECODE);
    step; expect_cyc("j_exec", 4'd9, CW_JUMP);
    step; expect_cyc("j_fetch", 4'd0, CW_FETCH);
    chk("beq_j_retire", RetireCount, 32'd4);

    // R-type
    Opcode = 6'h00;
    step; expect_cyc("r_decode", 4'd1, CW_DECODE);
    step; expect_cyc("r_exec", 4'd6, CW_EXEC);
    step; expect_cyc("r_aluwb", 4'd7, CW_ALUWB);
    step; expect_cyc("r_fetch", 4'd0, CW_FETCH);
    chk("r_retire", RetireCount, 32'd5);

    // addi
    Opcode = 6'h08;
`ifdef ADDI_SUPPORT_EN
    step; expect_cyc("addi_decode", 4'd1, CW_DECODE);
    step; expect_cyc("addi_ex", 4'd10, CW_MEMADR);
    step; expect_cyc("addi_wb", 4'd11, CW_ADDIWB);
    step; expect_cyc("addi_fetch", 4'd0, CW_FETCH);
    chk("addi_retire", RetireCount, 32'd6);
`else
    step; expect_cyc("addi_decode", 4'd1, CW_ILLEGAL);
    step; expect_cyc("addi_fetch", 4'd0, CW_FETCH);
    chk("addi_retire", RetireCount, 32'd5);
`endif

    // reset during a MEMRD stall
    Opcode = 6'h23;
    step; expect_cyc("rst_decode", 4'd1, CW_DECODE);
    step; expect_cyc("rst_memadr", 4'd2, CW_MEMADR);
    step; MemReady = 1'b0; #1; expect_cyc("rst_memrd", 4'd3, CW_MEMRD);
    step; expect_cyc("rst_memrd_stall", 4'd3, CW_MEMRD);
    reset = 1'b1; #1;
    expect_cyc("rst_abort", 4'd0, CW_ZERO);
    chk("rst_abort_retire", RetireCount, 32'd0);
    step; expect_cyc("rst_abort_held", 4'd0, CW_ZERO);
    reset = 1'b0; MemReady = 1'b1; #1;
    expect_cyc("rst_fetch", 4'd0, CW_FETCH);
    step; expect_cyc("rst_decode2", 4'd1, CW_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
